// File: rtl/rocev2_deadlock_reporter_if.sv
// Report-record channel from the deadlock reporter to its consumer.
// master: drives rpt_valid and the three snapshot vectors, samples rpt_ready.
// slave : samples the record, drives rpt_ready.
interface rocev2_deadlock_reporter_if #(
  parameter int N_PROC = 53,
  parameter int N_AXIS = 10
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [N_PROC-1:0] rpt_idle;
  logic [N_PROC-1:0] rpt_chan_block;
  logic [N_AXIS-1:0] rpt_axis_block;

  modport master (
    output rpt_valid, rpt_idle, rpt_chan_block, rpt_axis_block,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_idle, rpt_chan_block, rpt_axis_block,
    output rpt_ready
  );
endinterface

// File: rtl/rocev2_deadlock_reporter.sv
// Deadlock reporter: filters the dataflow monitor's block output, declaring a
// deadlock only after THRESH consecutive high samples. On declaration it sets
// a sticky flag, snapshots the status vectors and offers one report record.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   block_in            monitor block output
//   inst_idle_sigs      process idle vector      (N_PROC)
//   inst_block_sigs     process chan-block vector (N_PROC)
//   axis_block_sigs     axis block vector         (N_AXIS)
//   clear               software acknowledge/abort
//   deadlock            sticky deadlock-declared flag
//   rpt                 report record channel (valid/ready + snapshots)
//   event_count         saturating count of declared deadlocks
//   stall_cycles        saturating cycles deadlock has been high this event
module rocev2_deadlock_reporter #(
  parameter int N_PROC = 53,
  parameter int N_AXIS = 10,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [N_PROC-1:0]   inst_idle_sigs,
  input  logic [N_PROC-1:0]   inst_block_sigs,
  input  logic [N_AXIS-1:0]   axis_block_sigs,
  input  logic                clear,
  output logic                deadlock,
  rocev2_deadlock_reporter_if.master rpt,
  output logic [CNT_W-1:0]    event_count,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int              PW       = $clog2(THRESH + 1);
  localparam logic [PW-1:0]   LAST     = PW'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, COUNT, REPORT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     persist_q, persist_d;
  logic              trip;
  logic              valid_q;
  logic [N_PROC-1:0] snap_idle, snap_chan;
  logic [N_AXIS-1:0] snap_axis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      persist_q <= '0;
    end else begin
      state_q   <= state_d;
      persist_q <= persist_d;
    end
  end

  // clear is evaluated first and overrides everything, including a trip.
  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    trip      = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      persist_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (block_in) begin
            if (THRESH == 1) begin
              trip = 1'b1;
            end else begin
              persist_d = PW'(1);
              state_d   = COUNT;
            end
          end
        end
        COUNT: begin
          if (!block_in) begin
            persist_d = '0;
            state_d   = IDLE;
          end else if (persist_q == LAST) begin
            trip = 1'b1;
          end else begin
            persist_d = persist_q + PW'(1);
          end
        end
        REPORT: begin
          if (rpt.rpt_ready) state_d = HOLD;
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
      if (trip) begin
        state_d   = REPORT;
        persist_d = '0;
      end
    end
  end

  // Flags are registered from the next state so outputs stay flop-driven.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock     <= 1'b0;
      valid_q      <= 1'b0;
      snap_idle    <= '0;
      snap_chan    <= '0;
      snap_axis    <= '0;
      event_count  <= '0;
      stall_cycles <= '0;
    end else begin
      deadlock <= (state_d == REPORT) || (state_d == HOLD);
      valid_q  <= (state_d == REPORT);
      if (trip) begin
        snap_idle    <= inst_idle_sigs;
        snap_chan    <= inst_block_sigs;
        snap_axis    <= axis_block_sigs;
        stall_cycles <= '0;
        if (event_count != CNT_MAX) event_count <= event_count + CNT_W'(1);
      end else if (deadlock && !clear && stall_cycles != CNT_MAX) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  assign rpt.rpt_valid      = valid_q;
  assign rpt.rpt_idle       = snap_idle;
  assign rpt.rpt_chan_block = snap_chan;
  assign rpt.rpt_axis_block = snap_axis;

endmodule

// File: tb/tb_rocev2_deadlock_reporter.sv
// Bench for rocev2_deadlock_reporter: two instances (THRESH=4/CNT_W=16 and
// THRESH=1/CNT_W=2) driven by shared stimulus, compared every cycle against a
// run-length reference model, plus directed checks of the key scenarios.
module tb_rocev2_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset;
  logic        block_in;
  logic        clear;
  logic        rdy_a, rdy_b;
  logic [52:0] idle, chan;
  logic [9:0]  axis;

  logic        dl_a, dl_b;
  logic [15:0] ev_a, st_a;
  logic [1:0]  ev_b, st_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rocev2_deadlock_reporter_if #(.N_PROC(53), .N_AXIS(10)) if_a ();
  rocev2_deadlock_reporter_if #(.N_PROC(8),  .N_AXIS(4))  if_b ();

  assign if_a.rpt_ready = rdy_a;
  assign if_b.rpt_ready = rdy_b;

  rocev2_deadlock_reporter #(.N_PROC(53), .N_AXIS(10), .THRESH(4), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .block_in(block_in),
    .inst_idle_sigs(idle), .inst_block_sigs(chan), .axis_block_sigs(axis),
    .clear(clear), .deadlock(dl_a), .rpt(if_a.master),
    .event_count(ev_a), .stall_cycles(st_a)
  );

  rocev2_deadlock_reporter #(.N_PROC(8), .N_AXIS(4), .THRESH(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .block_in(block_in),
    .inst_idle_sigs(idle[7:0]), .inst_block_sigs(chan[7:0]), .axis_block_sigs(axis[3:0]),
    .clear(clear), .deadlock(dl_b), .rpt(if_b.master),
    .event_count(ev_b), .stall_cycles(st_b)
  );

  // Reference: a deadlock is declared when the current unbroken run of high
  // block samples (since the last clear or idle) reaches thresh.
  typedef struct {
    bit          declared;
    bit          reporting;
    int          run;
    int          events;
    int          stall;
    logic [52:0] idle;
    logic [52:0] chan;
    logic [9:0]  axis;
  } model_t;

  model_t ma, mb, na, nb;

  task automatic model_reset(output model_t m);
    m.declared = 0; m.reporting = 0; m.run = 0; m.events = 0; m.stall = 0;
    m.idle = '0; m.chan = '0; m.axis = '0;
  endtask

  task automatic model_step(input model_t m, input int thresh, input int cmax,
                            input bit rdy, output model_t o);
    o = m;
    if (clear) begin
      o.declared = 0; o.reporting = 0; o.run = 0;
    end else if (m.declared) begin
      if (m.reporting && rdy) o.reporting = 0;
      if (m.stall < cmax) o.stall = m.stall + 1;
    end else if (block_in) begin
      o.run = m.run + 1;
      if (o.run >= thresh) begin
        o.declared = 1; o.reporting = 1; o.run = 0; o.stall = 0;
        o.idle = idle; o.chan = chan; o.axis = axis;
        if (m.events < cmax) o.events = m.events + 1;
      end
    end else begin
      o.run = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_deadlock", 64'(dl_a), 64'(ma.declared));
    chk("a_valid",    64'(if_a.rpt_valid), 64'(ma.reporting));
    chk("a_idle",     64'(if_a.rpt_idle), 64'(ma.idle));
    chk("a_chan",     64'(if_a.rpt_chan_block), 64'(ma.chan));
    chk("a_axis",     64'(if_a.rpt_axis_block), 64'(ma.axis));
    chk("a_events",   64'(ev_a), 64'(ma.events));
    chk("a_stall",    64'(st_a), 64'(ma.stall));
    chk("b_deadlock", 64'(dl_b), 64'(mb.declared));
    chk("b_valid",    64'(if_b.rpt_valid), 64'(mb.reporting));
    chk("b_idle",     64'(if_b.rpt_idle), 64'(mb.idle[7:0]));
    chk("b_chan",     64'(if_b.rpt_chan_block), 64'(mb.chan[7:0]));
    chk("b_axis",     64'(if_b.rpt_axis_block), 64'(mb.axis[3:0]));
    chk("b_events",   64'(ev_b), 64'(mb.events));
    chk("b_stall",    64'(st_b), 64'(mb.stall));
  endtask

  // One clock: models advance on the edge with the inputs the DUT sampled,
  // outputs compared on the following falling edge.
  task automatic cyc();
    @(posedge clock);
    model_step(ma, 4, 65535, rdy_a, na);
    model_step(mb, 1, 3, rdy_b, nb);
    ma = na;
    mb = nb;
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input logic b, input logic c, input logic ra, input logic rb);
    block_in = b; clear = c; rdy_a = ra; rdy_b = rb;
  endtask

  logic [63:0] r64;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    idle = '0; chan = '0; axis = '0;
    model_reset(ma);
    model_reset(mb);
    #12;
    @(negedge clock);
    compare_all();
    chk("reset_dl_a", 64'(dl_a), 64'd0);
    reset = 1'b0;

    // Glitch restarts the count: 3 high, 1 low, 3 high, then low.
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int i = 0; i < 8; i++) begin
        drive(pat[i], 0, 0, 0);
        cyc();
        chk("t2_no_trip", 64'(dl_a), 64'd0);
      end
      chk("t2_events", 64'(ev_a), 64'd0);
    end

    // Trip on the 4th consecutive high sample with the given snapshot.
    idle = 53'h5; chan = 53'h3; axis = 10'h2A;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      cyc();
    end
    chk("t1_deadlock", 64'(dl_a), 64'd1);
    chk("t1_valid",    64'(if_a.rpt_valid), 64'd1);
    chk("t1_idle",     64'(if_a.rpt_idle), 64'h5);
    chk("t1_chan",     64'(if_a.rpt_chan_block), 64'h3);
    chk("t1_axis",     64'(if_a.rpt_axis_block), 64'h2A);
    chk("t1_events",   64'(ev_a), 64'd1);

    // Back-pressure for 5 cycles, then handshake; snapshot must not move.
    idle = 53'h1F; chan = 53'h1F; axis = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      cyc();
      chk("t3_valid_held", 64'(if_a.rpt_valid), 64'd1);
      chk("t3_snap_stable", 64'(if_a.rpt_idle), 64'h5);
    end
    drive(1, 0, 1, 0);
    cyc();
    chk("t3_valid_drop", 64'(if_a.rpt_valid), 64'd0);
    chk("t3_stall_hs",   64'(st_a), 64'd6);
    drive(1, 0, 0, 0);
    cyc();
    cyc();
    chk("t3_stall_hold", 64'(st_a), 64'd8);
    chk("t3_no_retrip",  64'(ev_a), 64'd1);

    // Clear, retrip, then abort the report with clear while not ready.
    drive(0, 1, 0, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      cyc();
    end
    chk("t4_tripped", 64'(if_a.rpt_valid), 64'd1);
    drive(1, 1, 0, 0);
    cyc();
    chk("t4_valid_abort", 64'(if_a.rpt_valid), 64'd0);
    chk("t4_dl_clear",    64'(dl_a), 64'd0);
    chk("t4_events",      64'(ev_a), 64'd2);

    // Block stays high after clear: re-trip exactly 4 cycles later.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 1);
      cyc();
      if (i < 3) chk("t5_not_yet", 64'(dl_a), 64'd0);
    end
    chk("t5_retrip",  64'(dl_a), 64'd1);
    chk("t5_events",  64'(ev_a), 64'd3);
    chk("t5_stall0",  64'(st_a), 64'd0);
    for (int i = 0; i < 10; i++) cyc();
    drive(1, 1, 1, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      cyc();
    end
    chk("t5_retrip2", 64'(ev_a), 64'd4);
    chk("t5_stall0b", 64'(st_a), 64'd0);

    // Async reset while a report is pending.
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_dl",    64'(dl_a), 64'd0);
    chk("t6_rst_valid", 64'(if_a.rpt_valid), 64'd0);
    chk("t6_rst_ev",    64'(ev_a), 64'd0);
    chk("t6_rst_idle",  64'(if_a.rpt_idle), 64'd0);
    model_reset(ma);
    model_reset(mb);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    cyc();

    // THRESH=1 trips on the first high sample; CNT_W=2 saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      cyc();
      chk("t6_b_trip1", 64'(dl_b), 64'd1);
      drive(0, 1, 0, 0);
      cyc();
    end
    chk("t6_b_sat", 64'(ev_b), 64'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      r64 = {$urandom(), $urandom()};
      idle = r64[52:0];
      r64 = {$urandom(), $urandom()};
      chan = r64[52:0];
      axis = 10'($urandom());
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
